// File: rtl/uart_word_transmit.sv
// uart_word_transmit: serialises a valid/ready-accepted word as back-to-back 8N1/8P2-style UART frames.
module uart_word_transmit #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 32,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  tx_wire_out
);
    localparam int BAUD_DIV  = CLK_FREQ / BAUD_RATE;
    localparam int NUM_BYTES = (DATA_WIDTH + 7) / 8;
    localparam int W         = NUM_BYTES * 8;
    localparam int CW        = $clog2(BAUD_DIV);
    localparam int BW        = $clog2(NUM_BYTES + 1);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [2:0]      r_bit, w_bit_n;
    logic            r_stop, w_stop_n;
    logic [BW-1:0]   r_byte, w_byte_n;
    logic [W-1:0]    r_word, w_word_n;
    logic            r_done, w_done_n;
    logic            r_tx, w_tx_n;
    logic            w_tick;
    logic [7:0]      w_cur_n;
    assign w_tick      = r_cnt == CW'(BAUD_DIV - 1);
    assign ready_out   = r_state == S_IDLE;
    assign busy_out    = ~ready_out;
    assign done_out    = r_done;
    assign tx_wire_out = r_tx;
    // The byte on air always sits at the shift-register edge matching the chosen byte order.
    assign w_cur_n = MSB_FIRST != 0 ? w_word_n[W-1 -: 8] : w_word_n[7:0];
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_tick ? '0 : r_cnt + 1'b1;
        w_bit_n   = r_bit;
        w_stop_n  = r_stop;
        w_byte_n  = r_byte;
        w_word_n  = r_word;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (valid_in) begin
                    w_state_n = S_START;
                    w_word_n  = W'(data_in);
                    w_bit_n   = '0;
                    w_stop_n  = 1'b0;
                    w_byte_n  = '0;
                end
            end
            S_START: if (w_tick) begin
                w_state_n = S_DATA;
                w_bit_n   = '0;
            end
            S_DATA: if (w_tick) begin
                w_bit_n  = r_bit + 1'b1;
                w_stop_n = 1'b0;
                if (r_bit == 3'd7) w_state_n = PARITY_EN != 0 ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_tick) w_state_n = S_STOP;
            S_STOP: if (w_tick) begin
                w_stop_n = r_stop + 1'b1;
                if (r_stop == 1'(STOP_BITS - 1)) begin
                    if (r_byte == BW'(NUM_BYTES - 1)) begin
                        w_state_n = S_IDLE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n = S_START;
                        w_byte_n  = r_byte + 1'b1;
                        w_word_n  = MSB_FIRST != 0 ? r_word << 8 : r_word >> 8;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        // The line level is registered from the next state, so tx_wire_out never glitches.
        w_tx_n = w_state_n == S_START  ? 1'b0 :
                 w_state_n == S_DATA   ? w_cur_n[w_bit_n] :
                 w_state_n == S_PARITY ? ((^w_cur_n) ^ 1'(PARITY_ODD)) : 1'b1;
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_byte  <= '0;
            r_word  <= '0;
            r_done  <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_stop  <= w_stop_n;
            r_byte  <= w_byte_n;
            r_word  <= w_word_n;
            r_done  <= w_done_n;
            r_tx    <= w_tx_n;
        end
    end
endmodule

// File: tb/tb_uart_word_transmit.sv
// tb_uart_word_transmit: table-driven frame checks across five parameterisations plus handshake/reset sequences.
module tb_uart_word_transmit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld [5];
    logic [15:0] dat [5];
    logic        rdy [5];
    logic        bsy [5];
    logic        dn  [5];
    logic        tx  [5];
    int          nvec = 0;
    int          nbad = 0;
    always #5 clk = ~clk;

    uart_word_transmit #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(16)) u0 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(dat[0]), .valid_in(vld[0]),
        .ready_out(rdy[0]), .busy_out(bsy[0]), .done_out(dn[0]), .tx_wire_out(tx[0]));
    uart_word_transmit #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(12), .MSB_FIRST(1)) u1 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(dat[1][11:0]), .valid_in(vld[1]),
        .ready_out(rdy[1]), .busy_out(bsy[1]), .done_out(dn[1]), .tx_wire_out(tx[1]));
    uart_word_transmit #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(12), .MSB_FIRST(0)) u2 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(dat[2][11:0]), .valid_in(vld[2]),
        .ready_out(rdy[2]), .busy_out(bsy[2]), .done_out(dn[2]), .tx_wire_out(tx[2]));
    uart_word_transmit #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(8), .PARITY_EN(1), .STOP_BITS(2)) u3 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(dat[3][7:0]), .valid_in(vld[3]),
        .ready_out(rdy[3]), .busy_out(bsy[3]), .done_out(dn[3]), .tx_wire_out(tx[3]));
    uart_word_transmit #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u4 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(dat[4][7:0]), .valid_in(vld[4]),
        .ready_out(rdy[4]), .busy_out(bsy[4]), .done_out(dn[4]), .tx_wire_out(tx[4]));

    typedef struct {
        int          dut;
        logic [15:0] data;
        int          nbits;
        logic [31:0] stream;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input int d, input logic [15:0] v);
        for (int i = 0; i < 1000 && !rdy[d]; i++) @(negedge clk);
        if (!rdy[d]) chk("send_ready_timeout", 32'(rdy[d]), 32'd1);
        dat[d] = v;
        vld[d] = 1'b1;
        @(posedge clk);
        #1 vld[d] = 1'b0;
    endtask

    // Cycle 1 follows the accepting edge; bit j is sampled mid-period in cycle 16*j+8.
    task automatic watch(input int d, input int nb, input int inj_at, input logic [15:0] inj_dat,
                         input int hold_at, input logic [15:0] hold_dat,
                         output logic [31:0] rx, output int dcyc, output int ndone, output logic [2:0] first);
        rx = '0;
        dcyc = -1;
        ndone = 0;
        first = '0;
        for (int c = 1; c <= nb * 16 + 1; c++) begin
            @(negedge clk);
            if (c == inj_at) begin dat[d] = inj_dat; vld[d] = 1'b1; end
            if (c == inj_at + 1) vld[d] = 1'b0;
            if (c == hold_at) begin dat[d] = hold_dat; vld[d] = 1'b1; end
            if (c == 1) first = {rdy[d], bsy[d], tx[d]};
            if (c <= nb * 16 && (c - 1) % 16 == 7) rx[(c - 1) / 16] = tx[d];
            if (dn[d]) begin ndone++; dcyc = c; end
        end
    endtask

    initial begin
        logic [31:0] rx;
        int          dcyc, ndone;
        logic [2:0]  first;
        for (int d = 0; d < 5; d++) begin vld[d] = 1'b0; dat[d] = '0; end
        tbl[0] = '{0, 16'hA55A, 20, 32'({1'b1, 8'hA5, 1'b0, 1'b1, 8'h5A, 1'b0})};
        tbl[1] = '{0, 16'h0001, 20, 32'({1'b1, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0})};
        tbl[2] = '{1, 16'h0ABC, 20, 32'({1'b1, 8'hBC, 1'b0, 1'b1, 8'h0A, 1'b0})};
        tbl[3] = '{2, 16'h0ABC, 20, 32'({1'b1, 8'h0A, 1'b0, 1'b1, 8'hBC, 1'b0})};
        tbl[4] = '{3, 16'h0007, 12, 32'({2'b11, 1'b1, 8'h07, 1'b0})};
        tbl[5] = '{4, 16'h0007, 12, 32'({2'b11, 1'b0, 8'h07, 1'b0})};
        tbl[6] = '{3, 16'h00FF, 12, 32'({2'b11, 1'b0, 8'hFF, 1'b0})};
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 5; d++) vld[d] = i[0];
            @(negedge clk);
            for (int d = 0; d < 5; d++) chk($sformatf("reset_hold_d%0d", d), 32'({tx[d], rdy[d], dn[d]}), 32'b110);
        end
        for (int d = 0; d < 5; d++) vld[d] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].dut, tbl[i].data);
            watch(tbl[i].dut, tbl[i].nbits, -5, '0, -5, '0, rx, dcyc, ndone, first);
            chk($sformatf("v%0d_stream", i), rx, tbl[i].stream);
            chk($sformatf("v%0d_first_cycle", i), 32'(first), 32'b010);
            chk($sformatf("v%0d_done_cycle", i), 32'(dcyc), 32'(tbl[i].nbits * 16 + 1));
            chk($sformatf("v%0d_done_count", i), 32'(ndone), 32'd1);
            chk($sformatf("v%0d_ready_at_done", i), 32'(rdy[tbl[i].dut]), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_done_after", i), 32'(dn[tbl[i].dut]), 32'd0);
        end
        send(3, 16'h0007);
        watch(3, 12, 40, 16'h0011, 150, 16'h0022, rx, dcyc, ndone, first);
        chk("hs_orig_stream", rx, 32'({2'b11, 1'b1, 8'h07, 1'b0}));
        chk("hs_orig_done", 32'(dcyc), 32'd193);
        chk("hs_orig_ndone", 32'(ndone), 32'd1);
        @(posedge clk);
        #1 vld[3] = 1'b0;
        watch(3, 12, -5, '0, -5, '0, rx, dcyc, ndone, first);
        chk("hs_held_first", 32'(first), 32'b010);
        chk("hs_held_stream", rx, 32'({2'b11, 1'b0, 8'h22, 1'b0}));
        chk("hs_held_done", 32'(dcyc), 32'd193);
        chk("hs_held_ndone", 32'(ndone), 32'd1);
        send(0, 16'hA55A);
        for (int c = 1; c <= 20; c++) @(negedge clk);
        chk("rst_mid_tx_before", 32'(tx[0]), 32'd0);
        rst_n = 1'b0;
        #1 chk("rst_mid_async", 32'({tx[0], rdy[0], bsy[0]}), 32'b110);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_mid_no_done", 32'(dn[0]), 32'd0);
        end
        rst_n = 1'b1;
        chk("rst_release_ready", 32'(rdy[0]), 32'd1);
        send(0, 16'h0055);
        watch(0, 20, -5, '0, -5, '0, rx, dcyc, ndone, first);
        chk("post_rst_stream", rx, 32'({1'b1, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0}));
        chk("post_rst_done", 32'(dcyc), 32'd321);
        chk("post_rst_ndone", 32'(ndone), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
